// File: rtl/des_key_schedule.sv
// DES subkey generator: PC-1 on load, then one rotate + PC-2 subkey per clock into 16 slots (reversed for decrypt).
// Latency: 17 edges from accepted key_load to keys_valid; key_load is ignored while key_busy is high.
module des_key_schedule (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [0:63]       key_in,
  input  logic              decrypt,
  input  logic              key_load,
  output logic              key_busy,
  output logic              keys_valid,
  output logic [0:15][0:47] round_keys
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

  // FIPS 46-3 tables, 1-based source bit numbers
  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[i] = k[6'(PC1_T[i] - 1)];
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[i] = cd[6'(PC2_T[i] - 1)];
    return r;
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic                w_load;
  logic [0:27]         r_c;
  logic [0:27]         r_d;
  logic [3:0]          r_rnd;
  logic                r_dir;
  logic [0:15][0:47]   r_round_keys;
  logic                w_single;
  logic [0:27]         w_c_rot;
  logic [0:27]         w_d_rot;
  logic [0:47]         w_subkey;
  logic [3:0]          w_slot;

  // Rounds 1, 2, 9 and 16 rotate by one; the rest by two (28 in total)
  assign w_single = (r_rnd == 4'd0) || (r_rnd == 4'd1) || (r_rnd == 4'd8) || (r_rnd == 4'd15);
  assign w_c_rot  = w_single ? {r_c[1:27], r_c[0]} : {r_c[2:27], r_c[0:1]};
  assign w_d_rot  = w_single ? {r_d[1:27], r_d[0]} : {r_d[2:27], r_d[0:1]};
  assign w_subkey = pc2({w_c_rot, w_d_rot});
  assign w_slot   = r_dir ? (4'd15 - r_rnd) : r_rnd;

  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (key_load) begin
          w_load       = 1'b1;
          w_next_state = S_GEN;
        end
      end
      S_GEN: begin
        if (r_rnd == 4'd15) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_c          <= '0;
      r_d          <= '0;
      r_rnd        <= '0;
      r_dir        <= 1'b0;
      r_round_keys <= '0;
    end else if (w_load) begin
      {r_c, r_d} <= pc1(key_in);
      r_dir      <= decrypt;
      r_rnd      <= '0;
    end else if (r_state == S_GEN) begin
      r_c                  <= w_c_rot;
      r_d                  <= w_d_rot;
      r_round_keys[w_slot] <= w_subkey;
      r_rnd                <= r_rnd + 4'd1;
    end
  end

  assign key_busy   = (r_state == S_GEN);
  assign keys_valid = (r_state == S_DONE);
  assign round_keys = r_round_keys;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: expected key sets are queued at stimulus time
// and a monitor compares all 16 slots whenever keys_valid rises.
module tb_des_key_schedule;

  typedef logic [0:15][0:47] keyset_t;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  // Published subkeys K1..K16 for KEY
  localparam logic [47:0] KF [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  logic              clk = 1'b0;
  logic              n_rst;
  logic [0:63]       key_in;
  logic              decrypt;
  logic              key_load;
  logic              key_busy;
  logic              keys_valid;
  logic [0:15][0:47] round_keys;

  keyset_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int sched = 0;

  des_key_schedule dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .key_in     (key_in),
    .decrypt    (decrypt),
    .key_load   (key_load),
    .key_busy   (key_busy),
    .keys_valid (keys_valid),
    .round_keys (round_keys)
  );

  always #5 clk = ~clk;

  function automatic keyset_t mk_set(input bit rev);
    keyset_t s;
    for (int i = 0; i < 16; i++) s[i] = rev ? KF[15 - i] : KF[i];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic load(input logic [63:0] k, input bit d);
    key_in   = k;
    decrypt  = d;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  // Counts edges E0..E16 inclusive; n0 is the count already consumed
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!keys_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!keys_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout waiting keys_valid: got 0 want 1");
    end
  endtask

  // Monitor: pop and compare on each keys_valid rising
  initial begin
    logic    prev_v;
    keyset_t exp;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (keys_valid === 1'b1 && prev_v !== 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected keys_valid: got 1 want 0");
        end else begin
          exp = q.pop_front();
          for (int i = 0; i < 16; i++)
            chk($sformatf("sched%0d slot%0d", sched, i), 64'(round_keys[i]), 64'(exp[i]));
          sched++;
        end
      end
      prev_v = keys_valid;
    end
  end

  initial begin
    int n;
    int busy_cnt;
    int pulses;
    int t_first;
    int t;

    // Reset with key_load asserted must hold IDLE
    n_rst    = 1'b0;
    key_load = 1'b1;
    key_in   = KEY;
    decrypt  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst key_busy", key_busy, 0);
    chk("rst keys_valid", keys_valid, 0);
    chk("rst round_keys", 64'(round_keys != '0), 0);
    key_load = 1'b0;
    n_rst    = 1'b1;
    @(posedge clk); #1;
    chk("idle key_busy", key_busy, 0);

    // Encrypt order
    q.push_back(mk_set(1'b0));
    load(KEY, 1'b0);
    chk("busy after E0", key_busy, 1);
    wait_done(1, n);
    chk("load-to-valid edges", n, 17);
    chk("busy at done", key_busy, 0);

    // Decrypt order
    q.push_back(mk_set(1'b1));
    load(KEY, 1'b1);
    wait_done(1, n);

    // key_load with a new key at E5 is ignored; busy spans E0..E16 = 16 clock periods
    q.push_back(mk_set(1'b0));
    load(KEY, 1'b0);
    n = 1;
    busy_cnt = int'(key_busy);
    while (!keys_valid && n < 40) begin
      if (n == 5) begin
        key_load = 1'b1;
        key_in   = 64'hFEDCBA9876543210;
        decrypt  = 1'b1;
      end
      if (n == 6) key_load = 1'b0;
      @(posedge clk); #1;
      n++;
      busy_cnt += int'(key_busy);
    end
    chk("midgen load edges", n, 17);
    chk("busy periods", busy_cnt, 16);
    key_in  = KEY;
    decrypt = 1'b0;

    // Parity bits ignored
    q.push_back(mk_set(1'b0));
    load(KEY ^ 64'h0101010101010101, 1'b0);
    wait_done(1, n);

    // key_load held high: one-cycle keys_valid pulse every 17 edges
    q.push_back(mk_set(1'b0));
    q.push_back(mk_set(1'b0));
    key_in   = KEY;
    decrypt  = 1'b0;
    key_load = 1'b1;
    pulses   = 0;
    t_first  = 0;
    t        = 0;
    while (pulses < 2 && t < 80) begin
      @(posedge clk); #1;
      t++;
      if (keys_valid) begin
        pulses++;
        if (pulses == 1) t_first = t;
      end
    end
    key_load = 1'b0;
    chk("held-load pulses", pulses, 2);
    chk("held-load period", t - t_first, 17);

    // Reset sampled at E8 aborts the schedule
    load(KEY, 1'b0);
    repeat (7) begin
      @(posedge clk); #1;
    end
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    chk("abort key_busy", key_busy, 0);
    chk("abort keys_valid", keys_valid, 0);
    chk("abort round_keys", 64'(round_keys != '0), 0);
    q.push_back(mk_set(1'b0));
    load(KEY, 1'b0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("reload slot7 at E8", 64'(round_keys[7]), 64'(KF[7]));
    chk("reload slots8-15 zero", 64'(round_keys[8:15] != '0), 0);
    chk("reload keys_valid at E8", keys_valid, 0);
    wait_done(9, n);
    chk("reload edges", n, 17);

    repeat (2) @(posedge clk);
    chk("queue drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
